// File: rtl/pci_cfg_if.sv
// Config-access channel between the PCI target state machine (master)
// and the Type-0 configuration space (slave).
interface pci_cfg_if;
  logic        cfg_req;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [3:0]  cfg_be;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ack;

  modport master (
    output cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata,
    input  cfg_rdata, cfg_ack
  );

  modport slave (
    input  cfg_req, cfg_we, cfg_addr, cfg_be, cfg_wdata,
    output cfg_rdata, cfg_ack
  );
endinterface

// File: rtl/pci_cfg_space.sv
// PCI Type-0 configuration space: ID/class constants, command/status, sizable BARs,
// interrupt pin/line and registered BAR decode. Define CFG_ROM_BAR_EN for the expansion ROM BAR.
module pci_cfg_space #(
  parameter logic [31:0]  VENDOR_DEVICE = 32'h0301_10ee,
  parameter logic [31:0]  CC_REVISION   = 32'h0b40_0000,
  parameter logic [31:0]  SUBSYS        = 32'h0000_0000,
  parameter int unsigned  NUM_BARS      = 2,
  parameter logic [191:0] BAR_MASKS     = {{4{32'h0}}, 32'hffff_0000, 32'hffff_fff0},
  parameter logic [5:0]   BAR_IO        = 6'b000001,
  parameter logic [5:0]   BAR_PREF      = 6'b000000
`ifdef CFG_ROM_BAR_EN
  ,
  parameter logic [31:0]  ROM_MASK      = 32'hffff_0000
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  pci_cfg_if.slave    cfg,
  input  logic [31:0] dec_addr,
  input  logic        dec_io,
  input  logic        dec_valid,
  output logic [5:0]  bar_hit,
  output logic        rom_hit,
  input  logic        int_req,
  input  logic        stat_rta,
  input  logic        stat_rma,
  output logic        cmd_io_en,
  output logic        cmd_mem_en,
  output logic        cmd_bm_en,
  output logic        inta_n
);

  localparam logic [15:0] CmdRwMask = 16'h0547;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q;
  logic [5:0]  addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic [15:0] cmd_q, cmd_d;
  logic        rta_q, rta_d, rma_q, rma_d;
  logic [7:0]  cls_q, cls_d, lat_q, lat_d, int_line_q, int_line_d;
  logic [5:0]  bar_hit_q, hit_d;
  logic        inta_n_q;
  logic [31:0] bar_rd [6];
  logic [31:0] rom_rd;
  logic [31:0] rd_val;
  logic        wr_en;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  assign wr_en = (state_q == StAccess) && we_q;

  for (genvar g = 0; g < 6; g++) begin : g_bar
    if (g < NUM_BARS) begin : g_impl
      localparam logic [31:0] Mask     = BAR_MASKS[32*g +: 32];
      localparam logic [31:0] TypeBits = BAR_IO[g] ? 32'h1 : {28'h0, BAR_PREF[g], 3'b000};
      logic        sel;
      logic [31:0] base_q;

      assign sel = (addr_q == 6'(4 + g));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          base_q <= '0;
        end else if (wr_en && sel) begin
          base_q <= merge(base_q, wdata_q, be_q) & Mask;
        end
      end

      assign bar_rd[g] = sel ? (base_q | TypeBits) : '0;
      // Zero base means "unassigned", never a hit.
      assign hit_d[g]  = dec_valid && (dec_io == BAR_IO[g]) &&
                         (BAR_IO[g] ? cmd_q[0] : cmd_q[1]) &&
                         (base_q != '0) && ((dec_addr & Mask) == base_q);
    end else begin : g_none
      assign bar_rd[g] = '0;
      assign hit_d[g]  = 1'b0;
    end
  end

`ifdef CFG_ROM_BAR_EN
  localparam logic [31:0] RomAddrMask = ROM_MASK & 32'hffff_f800;
  logic [31:0] rom_q;
  logic        rom_hit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_q     <= '0;
      rom_hit_q <= 1'b0;
    end else begin
      if (wr_en && (addr_q == 6'd12)) rom_q <= merge(rom_q, wdata_q, be_q) & (RomAddrMask | 32'h1);
      rom_hit_q <= dec_valid && !dec_io && cmd_q[1] && rom_q[0] &&
                   ((dec_addr & RomAddrMask) == {rom_q[31:1], 1'b0});
    end
  end

  assign rom_rd  = (addr_q == 6'd12) ? rom_q : '0;
  assign rom_hit = rom_hit_q;
`else
  assign rom_rd  = '0;
  assign rom_hit = 1'b0;
`endif

  always_comb begin
    rd_val = '0;
    case (addr_q)
      6'd0:    rd_val = VENDOR_DEVICE;
      6'd1:    rd_val = {2'b0, rma_q, rta_q, 8'b0, int_req, 3'b0, cmd_q};
      6'd2:    rd_val = CC_REVISION;
      6'd3:    rd_val = {16'b0, lat_q, cls_q};
      6'd11:   rd_val = SUBSYS;
      6'd15:   rd_val = {16'b0, 8'h01, int_line_q};
      default: rd_val = '0;
    endcase
    for (int n = 0; n < 6; n++) rd_val = rd_val | bar_rd[n];
    rd_val = rd_val | rom_rd;
  end

  always_comb begin
    state_d    = state_q;
    rdata_d    = '0;
    cmd_d      = cmd_q;
    cls_d      = cls_q;
    lat_d      = lat_q;
    int_line_d = int_line_q;
    rta_d      = rta_q | stat_rta;
    rma_d      = rma_q | stat_rma;
    unique case (state_q)
      StIdle:   if (cfg.cfg_req) state_d = StAccess;
      StAccess: begin
        state_d = StDone;
        if (!we_q) rdata_d = rd_val;
      end
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (wr_en) begin
      case (addr_q)
        6'd1: begin
          if (be_q[0]) cmd_d[7:0]  = wdata_q[7:0] & CmdRwMask[7:0];
          if (be_q[1]) cmd_d[15:8] = wdata_q[15:8] & CmdRwMask[15:8];
          // Incoming status pulses take priority over a same-cycle clear.
          if (be_q[3]) begin
            rta_d = stat_rta | (rta_q & ~wdata_q[28]);
            rma_d = stat_rma | (rma_q & ~wdata_q[29]);
          end
        end
        6'd3: begin
          if (be_q[0]) cls_d = wdata_q[7:0];
          if (be_q[1]) lat_d = wdata_q[15:8];
        end
        6'd15:   if (be_q[0]) int_line_d = wdata_q[7:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cmd_q      <= '0;
      rta_q      <= 1'b0;
      rma_q      <= 1'b0;
      cls_q      <= '0;
      lat_q      <= '0;
      int_line_q <= '0;
      bar_hit_q  <= '0;
      inta_n_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      rdata_q    <= rdata_d;
      cmd_q      <= cmd_d;
      rta_q      <= rta_d;
      rma_q      <= rma_d;
      cls_q      <= cls_d;
      lat_q      <= lat_d;
      int_line_q <= int_line_d;
      bar_hit_q  <= hit_d;
      inta_n_q   <= ~(int_req & ~cmd_q[10]);
      if (state_q == StIdle && cfg.cfg_req) begin
        we_q    <= cfg.cfg_we;
        addr_q  <= cfg.cfg_addr;
        be_q    <= cfg.cfg_be;
        wdata_q <= cfg.cfg_wdata;
      end
    end
  end

  assign cfg.cfg_rdata = rdata_q;
  assign cfg.cfg_ack   = (state_q == StDone);
  assign bar_hit       = bar_hit_q;
  assign cmd_io_en     = cmd_q[0];
  assign cmd_mem_en    = cmd_q[1];
  assign cmd_bm_en     = cmd_q[2];
  assign inta_n        = inta_n_q;

endmodule

// File: tb/tb_pci_cfg_space.sv
// Directed bench for pci_cfg_space (default build, CFG_ROM_BAR_EN undefined).
module tb_pci_cfg_space;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] dec_addr;
  logic        dec_io, dec_valid;
  logic [5:0]  bar_hit;
  logic        rom_hit;
  logic        int_req, stat_rta, stat_rma;
  logic        cmd_io_en, cmd_mem_en, cmd_bm_en, inta_n;
  int          checks = 0;
  int          errors = 0;

  pci_cfg_if ifc ();

  pci_cfg_space dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (ifc),
    .dec_addr   (dec_addr),
    .dec_io     (dec_io),
    .dec_valid  (dec_valid),
    .bar_hit    (bar_hit),
    .rom_hit    (rom_hit),
    .int_req    (int_req),
    .stat_rta   (stat_rta),
    .stat_rma   (stat_rma),
    .cmd_io_en  (cmd_io_en),
    .cmd_mem_en (cmd_mem_en),
    .cmd_bm_en  (cmd_bm_en),
    .inta_n     (inta_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One config access; lat counts cycles from the REQ-sampling cycle to the ACK cycle.
  task automatic cfg_xfer(input logic we, input logic [5:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic rma_pulse,
                          output logic [31:0] rd, output int lat);
    logic got;
    @(posedge clk); #1;
    ifc.cfg_req = 1'b1; ifc.cfg_we = we; ifc.cfg_addr = a; ifc.cfg_be = be; ifc.cfg_wdata = wd;
    @(posedge clk); #1;
    ifc.cfg_we = 1'bx; ifc.cfg_wdata = 32'hdead_beef;
    stat_rma = rma_pulse;
    lat = 1; got = 1'b0; rd = 'x;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ifc.cfg_ack) begin
        got = 1'b1; rd = ifc.cfg_rdata; ifc.cfg_req = 1'b0;
      end else begin
        @(posedge clk); #1;
        stat_rma = 1'b0;
        lat++;
      end
    end
    ifc.cfg_req = 1'b0; ifc.cfg_we = 1'b0; stat_rma = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp);
    logic [31:0] d;
    int lat;
    cfg_xfer(1'b0, a, 4'h0, 32'h0, 1'b0, d, lat);
    check({tag, "_lat"}, 32'(lat), 32'd2);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] wd,
                    input logic rma_pulse);
    logic [31:0] d;
    int lat;
    cfg_xfer(1'b1, a, be, wd, rma_pulse, d, lat);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_rdata", d, 32'h0);
  endtask

  task automatic dec_chk(input string tag, input logic [31:0] a, input logic io, input logic v,
                         input logic [5:0] exp);
    @(posedge clk); #1;
    dec_addr = a; dec_io = io; dec_valid = v;
    @(posedge clk);
    @(negedge clk);
    check(tag, {26'h0, bar_hit}, {26'h0, exp});
    dec_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ifc.cfg_req = 1'b0; ifc.cfg_we = 1'b0; ifc.cfg_addr = '0; ifc.cfg_be = '0;
    ifc.cfg_wdata = '0;
    dec_addr = '0; dec_io = 1'b0; dec_valid = 1'b0;
    int_req = 1'b0; stat_rta = 1'b0; stat_rma = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'h0, ifc.cfg_ack}, 32'h0);
    check("rst_rdata", ifc.cfg_rdata, 32'h0);
    check("rst_bar_hit", {26'h0, bar_hit}, 32'h0);
    check("rst_inta_n", {31'h0, inta_n}, 32'h1);
    @(posedge clk); #1 rst_n = 1'b1;

    rd_chk("id", 6'd0, 32'h0301_10ee);
    rd_chk("class", 6'd2, 32'h0b40_0000);
    check("cmd_en_rst", {29'h0, cmd_bm_en, cmd_mem_en, cmd_io_en}, 32'h0);
    check("inta_idle", {31'h0, inta_n}, 32'h1);
    check("rom_hit_off", {31'h0, rom_hit}, 32'h0);

    // BAR sizing
    wr(6'd4, 4'hf, 32'hffff_ffff, 1'b0);
    wr(6'd5, 4'hf, 32'hffff_ffff, 1'b0);
    rd_chk("bar0_size", 6'd4, 32'hffff_fff1);
    rd_chk("bar1_size", 6'd5, 32'hffff_0000);
    rd_chk("bar2_none", 6'd6, 32'h0);

    // Memory decode through BAR1
    wr(6'd5, 4'hf, 32'h8000_0000, 1'b0);
    dec_chk("hit_mem_dis", 32'h8000_1234, 1'b0, 1'b1, 6'b000000);
    wr(6'd1, 4'b0001, 32'h0000_0002, 1'b0);
    rd_chk("cmd_mem", 6'd1, 32'h0000_0002);
    check("cmd_mem_en", {29'h0, cmd_bm_en, cmd_mem_en, cmd_io_en}, 32'h2);
    dec_chk("hit_bar1", 32'h8000_1234, 1'b0, 1'b1, 6'b000010);
    dec_chk("miss_addr", 32'h9000_0000, 1'b0, 1'b1, 6'b000000);
    dec_chk("miss_valid", 32'h8000_1234, 1'b0, 1'b0, 6'b000000);
    dec_chk("miss_io_dis", 32'hffff_fff7, 1'b1, 1'b1, 6'b000000);

    // Sticky W1C status with set-priority
    @(posedge clk); #1 stat_rma = 1'b1; stat_rta = 1'b1;
    @(posedge clk); #1 stat_rma = 1'b0; stat_rta = 1'b0;
    rd_chk("stat_set", 6'd1, 32'h3000_0002);
    wr(6'd1, 4'b1000, 32'h2000_0000, 1'b1);
    rd_chk("stat_set_wins", 6'd1, 32'h3000_0002);
    wr(6'd1, 4'b1000, 32'h3000_0000, 1'b0);
    rd_chk("stat_clear", 6'd1, 32'h0000_0002);

    // Interrupt
    @(posedge clk); #1 int_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("inta_assert", {31'h0, inta_n}, 32'h0);
    rd_chk("stat_int", 6'd1, 32'h0008_0002);
    wr(6'd1, 4'b0011, 32'h0000_0402, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("inta_masked", {31'h0, inta_n}, 32'h1);
    rd_chk("cmd_intdis", 6'd1, 32'h0008_0402);
    wr(6'd1, 4'b0011, 32'h0000_ffff, 1'b0);
    rd_chk("cmd_rw_mask", 6'd1, 32'h0008_0547);
    check("cmd_all_en", {29'h0, cmd_bm_en, cmd_mem_en, cmd_io_en}, 32'h7);
    dec_chk("hit_bar0_io", 32'hffff_fff7, 1'b1, 1'b1, 6'b000001);
    dec_chk("hit_bar1_again", 32'h8000_0010, 1'b0, 1'b1, 6'b000010);

    // Misc registers and holes
    wr(6'd3, 4'hf, 32'hffff_ffff, 1'b0);
    rd_chk("cls_lat", 6'd3, 32'h0000_ffff);
    wr(6'd3, 4'b0010, 32'h0000_1200, 1'b0);
    rd_chk("cls_lat_be", 6'd3, 32'h0000_12ff);
    wr(6'd15, 4'hf, 32'hffff_ffab, 1'b0);
    rd_chk("int_line", 6'd15, 32'h0000_01ab);
    rd_chk("subsys", 6'd11, 32'h0);
    wr(6'd12, 4'hf, 32'hffff_ffff, 1'b0);
    rd_chk("rom_absent", 6'd12, 32'h0);
    wr(6'd20, 4'hf, 32'hffff_ffff, 1'b0);
    rd_chk("unlisted", 6'd20, 32'h0);

    // Reset during the ACCESS cycle of a write to 0x3C
    int_req = 1'b0;
    @(posedge clk); #1;
    ifc.cfg_req = 1'b1; ifc.cfg_we = 1'b1; ifc.cfg_addr = 6'd15; ifc.cfg_be = 4'b0001;
    ifc.cfg_wdata = 32'h0000_0055;
    @(posedge clk); #2;
    rst_n = 1'b0; ifc.cfg_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_ack", {31'h0, ifc.cfg_ack}, 32'h0);
    end
    check("rst_cmd", {29'h0, cmd_bm_en, cmd_mem_en, cmd_io_en}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd_chk("int_line_rst", 6'd15, 32'h0000_0100);
    rd_chk("bar1_rst", 6'd5, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
